awb_gain_apply: RTL and testbench

- Downstream consumer of the AWB gain calculator.
- Captures the r/g/b gains on each gain_ready pulse and holds them as pending until the next frame_start, so gains never change mid-frame.
- Multiplies each raw Bayer pixel by the gain of its colour channel, then rounds and saturates the result to 8 bits.
- Sits in the raw pipeline between the Bayer pattern tracker and the demosaic stage; 3-cycle fixed latency.

---
 rtl/awb_pkg.sv | 14 +
 rtl/awb_pixel_mul.sv | 52 +++++
 rtl/awb_gain_apply.sv | 118 +++++++++++
 tb/tb_awb_gain_apply.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/awb_pkg.sv
// Shared constants for the AWB gain path: unity gain, Bayer tag bit positions
// and the pixel saturation limit.
package awb_pkg;

  localparam int GAIN_UNITY = 64;

  localparam int BAYER_G0 = 0;
  localparam int BAYER_B  = 1;
  localparam int BAYER_R  = 2;
  localparam int BAYER_G1 = 3;

  localparam int PIX_MAX = 255;

endpackage

// File: rtl/awb_pixel_mul.sv
// Two-stage pixel multiplier: registered din*gain product, then round-half-up
// by the gain fraction and saturate to the pixel width.
module awb_pixel_mul #(
  parameter int DATA_W    = 8,
  parameter int GAIN_W    = 8,
  parameter int GAIN_FRAC = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic [GAIN_W-1:0] gain,
  input  logic              valid,
  input  logic [3:0]        tag,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic [3:0]        dout_tag
);

  localparam int PROD_W = DATA_W + GAIN_W;
  localparam int SUM_W  = PROD_W + 1;
  localparam logic [SUM_W-1:0] HALF = SUM_W'(1) << (GAIN_FRAC - 1);
  localparam logic [SUM_W-1:0] MAXV = {{(SUM_W-DATA_W){1'b0}}, {DATA_W{1'b1}}};

  logic [PROD_W-1:0] prod_q;
  logic              valid_q;
  logic [3:0]        tag_q;
  logic [SUM_W-1:0]  rounded;

  // One spare bit so adding the rounding half can never wrap.
  always_comb begin
    rounded = ({1'b0, prod_q} + HALF) >> GAIN_FRAC;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q     <= '0;
      valid_q    <= 1'b0;
      tag_q      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_tag   <= '0;
    end else begin
      prod_q     <= PROD_W'(din) * PROD_W'(gain);
      valid_q    <= valid;
      tag_q      <= tag;
      dout       <= (rounded > MAXV) ? MAXV[DATA_W-1:0] : rounded[DATA_W-1:0];
      dout_valid <= valid_q;
      dout_tag   <= tag_q;
    end
  end

endmodule

// File: rtl/awb_gain_apply.sv
// Applies per-channel AWB gains to raw Bayer pixels; new gains are shadowed
// and only committed at frame_start so a frame never sees a gain change.
module awb_gain_apply
  import awb_pkg::*;
#(
  parameter int GAIN_W    = 8,
  parameter int GAIN_FRAC = 6,
  parameter int DATA_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clken,
  input  logic [DATA_W-1:0] din,
  input  logic [3:0]        bayer_state,
  input  logic              frame_start,
  input  logic [GAIN_W-1:0] r_gain_cal,
  input  logic [GAIN_W-1:0] g_gain_cal,
  input  logic [GAIN_W-1:0] b_gain_cal,
  input  logic              gain_ready,
  input  logic              bypass,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic [3:0]        dout_bayer_state,
  output logic              gain_pending,
  output logic              gain_applied
);

  localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(1) << GAIN_FRAC;

  logic [GAIN_W-1:0] r_act, g_act, b_act;
  logic [GAIN_W-1:0] r_pend, g_pend, b_pend;
  logic [GAIN_W-1:0] sel_gain;
  logic [GAIN_W-1:0] s1_gain;
  logic [DATA_W-1:0] s1_din;
  logic              s1_valid;
  logic [3:0]        s1_tag;

  // A simultaneous gain_ready + frame_start bypasses the shadow and commits at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_act        <= UNITY;
      g_act        <= UNITY;
      b_act        <= UNITY;
      r_pend       <= UNITY;
      g_pend       <= UNITY;
      b_pend       <= UNITY;
      gain_pending <= 1'b0;
      gain_applied <= 1'b0;
    end else if (gain_ready && frame_start) begin
      r_act        <= r_gain_cal;
      g_act        <= g_gain_cal;
      b_act        <= b_gain_cal;
      r_pend       <= r_gain_cal;
      g_pend       <= g_gain_cal;
      b_pend       <= b_gain_cal;
      gain_pending <= 1'b0;
      gain_applied <= 1'b1;
    end else begin
      gain_applied <= 1'b0;
      if (frame_start && gain_pending) begin
        r_act        <= r_pend;
        g_act        <= g_pend;
        b_act        <= b_pend;
        gain_pending <= 1'b0;
        gain_applied <= 1'b1;
      end
      if (gain_ready) begin
        r_pend       <= r_gain_cal;
        g_pend       <= g_gain_cal;
        b_pend       <= b_gain_cal;
        gain_pending <= 1'b1;
      end
    end
  end

  always_comb begin
    sel_gain = UNITY;
    if (!bypass) begin
      if (bayer_state[BAYER_R])
        sel_gain = r_act;
      else if (bayer_state[BAYER_B])
        sel_gain = b_act;
      else if (bayer_state[BAYER_G0] || bayer_state[BAYER_G1])
        sel_gain = g_act;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_din   <= '0;
      s1_valid <= 1'b0;
      s1_tag   <= '0;
      s1_gain  <= '0;
    end else begin
      s1_din   <= din;
      s1_valid <= clken;
      s1_tag   <= bayer_state;
      s1_gain  <= sel_gain;
    end
  end

  awb_pixel_mul #(
    .DATA_W    (DATA_W),
    .GAIN_W    (GAIN_W),
    .GAIN_FRAC (GAIN_FRAC)
  ) u_mul (
    .clk        (clk),
    .rst        (rst),
    .din        (s1_din),
    .gain       (s1_gain),
    .valid      (s1_valid),
    .tag        (s1_tag),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_tag   (dout_bayer_state)
  );

endmodule

// File: tb/tb_awb_gain_apply.sv
// Bench for awb_gain_apply: stimulus records carry their expected dout, which
// a scoreboard queue matches against DUT output together with tag and latency.
module tb_awb_gain_apply;
  import awb_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clken = 1'b0;
  logic [7:0] din = '0;
  logic [3:0] bayer_state = '0;
  logic       frame_start = 1'b0;
  logic [7:0] r_gain_cal = '0, g_gain_cal = '0, b_gain_cal = '0;
  logic       gain_ready = 1'b0;
  logic       bypass = 1'b0;
  logic [7:0] dout;
  logic       dout_valid;
  logic [3:0] dout_bayer_state;
  logic       gain_pending;
  logic       gain_applied;

  typedef struct {
    logic       ce;
    logic [7:0] d;
    logic [3:0] tag;
    logic       byp;
    logic       fs;
    logic       gr;
    logic [7:0] rg, gg, bg;
    int         exp;
  } vec_t;

  typedef struct {
    int         exp;
    logic [3:0] tag;
    int         cyc;
  } sb_t;

  sb_t  sb[$];
  vec_t tbl[$];
  int   cycle = 0;
  int   n_compared = 0;
  int   n_mismatched = 0;

  awb_gain_apply #(.GAIN_W(8), .GAIN_FRAC(6), .DATA_W(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .clken            (clken),
    .din              (din),
    .bayer_state      (bayer_state),
    .frame_start      (frame_start),
    .r_gain_cal       (r_gain_cal),
    .g_gain_cal       (g_gain_cal),
    .b_gain_cal       (b_gain_cal),
    .gain_ready       (gain_ready),
    .bypass           (bypass),
    .dout             (dout),
    .dout_valid       (dout_valid),
    .dout_bayer_state (dout_bayer_state),
    .gain_pending     (gain_pending),
    .gain_applied     (gain_applied)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input int act, input int exp);
    n_compared++;
    if (act != exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic vec_t mkPix(input int d, input logic [3:0] tag, input logic byp, input int exp);
    vec_t v;
    v = '{ce: 1'b1, d: 8'(d), tag: tag, byp: byp, fs: 1'b0, gr: 1'b0,
          rg: 8'd0, gg: 8'd0, bg: 8'd0, exp: exp};
    return v;
  endfunction

  function automatic vec_t mkCtl(input logic fs, input logic gr, input int r, input int g, input int b);
    vec_t v;
    v = '{ce: 1'b0, d: 8'd0, tag: 4'd0, byp: 1'b0, fs: fs, gr: gr,
          rg: 8'(r), gg: 8'(g), bg: 8'(b), exp: 0};
    return v;
  endfunction

  // Drives one cycle of inputs; valid pixels push their expectation first.
  task automatic applyStimulus(input vec_t v);
    clken       = v.ce;
    din         = v.d;
    bayer_state = v.tag;
    bypass      = v.byp;
    frame_start = v.fs;
    gain_ready  = v.gr;
    r_gain_cal  = v.rg;
    g_gain_cal  = v.gg;
    b_gain_cal  = v.bg;
    if (v.ce) sb.push_back('{exp: v.exp, tag: v.tag, cyc: cycle + 3});
    @(posedge clk);
    #1;
    clken       = 1'b0;
    frame_start = 1'b0;
    gain_ready  = 1'b0;
    bypass      = 1'b0;
  endtask

  task automatic runTable();
    foreach (tbl[i]) applyStimulus(tbl[i]);
    tbl.delete();
  endtask

  always @(negedge clk) begin
    sb_t e;
    if (!rst && dout_valid) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        checkOutput("dout", int'(dout), e.exp);
        checkOutput("dout_tag", int'(dout_bayer_state), int'(e.tag));
        checkOutput("latency", cycle, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] rd;
    logic [3:0] rt;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rst_dout", int'(dout), 0);
    checkOutput("rst_valid", int'(dout_valid), 0);
    checkOutput("rst_pending", int'(gain_pending), 0);
    checkOutput("rst_applied", int'(gain_applied), 0);

    // No gains ever loaded: every channel is unity.
    tbl.push_back(mkPix(100, 4'b0100, 1'b0, 100));
    tbl.push_back(mkPix(100, 4'b0010, 1'b0, 100));
    tbl.push_back(mkPix(100, 4'b0001, 1'b0, 100));
    tbl.push_back(mkPix(100, 4'b1000, 1'b0, 100));
    runTable();
    checkOutput("t1_pending", int'(gain_pending), 0);

    applyStimulus(mkCtl(1'b0, 1'b1, 96, 64, 32));
    checkOutput("t2_pending_set", int'(gain_pending), 1);
    applyStimulus(mkCtl(1'b0, 1'b0, 0, 0, 0));
    checkOutput("t2_pending_hold", int'(gain_pending), 1);
    checkOutput("t2_no_early_apply", int'(gain_applied), 0);
    applyStimulus(mkCtl(1'b1, 1'b0, 0, 0, 0));
    checkOutput("t2_applied_pulse", int'(gain_applied), 1);
    checkOutput("t2_pending_clr", int'(gain_pending), 0);
    applyStimulus(mkPix(100, 4'b0100, 1'b0, 150));
    checkOutput("t2_applied_end", int'(gain_applied), 0);
    applyStimulus(mkPix(100, 4'b0001, 1'b0, 100));
    applyStimulus(mkPix(100, 4'b0010, 1'b0, 50));

    // Mid-frame gain_ready must not disturb the running frame.
    applyStimulus(mkPix(100, 4'b0100, 1'b0, 150));
    applyStimulus(mkCtl(1'b0, 1'b1, 128, 64, 32));
    applyStimulus(mkPix(100, 4'b0100, 1'b0, 150));
    checkOutput("t3_pending", int'(gain_pending), 1);
    applyStimulus(mkCtl(1'b1, 1'b0, 0, 0, 0));
    applyStimulus(mkPix(100, 4'b0100, 1'b0, 200));

    tbl.push_back(mkPix(200, 4'b0100, 1'b0, 255));
    tbl.push_back(mkPix(255, 4'b0100, 1'b0, 255));
    tbl.push_back(mkPix(127, 4'b0100, 1'b0, 254));
    tbl.push_back(mkPix(3,   4'b0010, 1'b0, 2));
    tbl.push_back(mkPix(1,   4'b0010, 1'b0, 1));
    tbl.push_back(mkPix(0,   4'b0010, 1'b0, 0));
    tbl.push_back(mkPix(100, 4'b1000, 1'b0, 100));
    runTable();

    // Last gain_ready before the commit wins.
    applyStimulus(mkCtl(1'b0, 1'b1, 128, 64, 16));
    applyStimulus(mkCtl(1'b0, 1'b1, 128, 64, 48));
    applyStimulus(mkCtl(1'b1, 1'b0, 0, 0, 0));
    applyStimulus(mkPix(100, 4'b0010, 1'b0, 75));

    applyStimulus(mkCtl(1'b1, 1'b1, 128, 80, 48));
    checkOutput("t5_pending", int'(gain_pending), 0);
    checkOutput("t5_applied", int'(gain_applied), 1);
    applyStimulus(mkPix(64, 4'b1000, 1'b0, 80));
    checkOutput("t5_applied_end", int'(gain_applied), 0);
    applyStimulus(mkPix(100, 4'b0001, 1'b0, 125));

    tbl.push_back(mkPix(100, 4'b0100, 1'b1, 100));
    tbl.push_back(mkPix(77,  4'b0000, 1'b0, 77));
    tbl.push_back(mkPix(100, 4'b0100, 1'b0, 200));
    tbl.push_back(mkPix(255, 4'b0010, 1'b1, 255));
    for (int i = 0; i < 6; i++) begin
      rd = 8'($urandom_range(0, 255));
      rt = 4'($urandom_range(0, 15));
      tbl.push_back(mkPix(int'(rd), rt, 1'b1, int'(rd)));
    end
    runTable();

    // Reset with live pixels in flight.
    applyStimulus(mkPix(100, 4'b0100, 1'b0, 200));
    applyStimulus(mkPix(100, 4'b0100, 1'b0, 200));
    applyStimulus(mkPix(100, 4'b0100, 1'b0, 200));
    checkOutput("t6_valid_pre_rst", int'(dout_valid), 1);
    rst = 1'b1;
    #1;
    checkOutput("t6_valid_rst", int'(dout_valid), 0);
    checkOutput("t6_dout_rst", int'(dout), 0);
    sb.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("t6_pending_rst", int'(gain_pending), 0);
    checkOutput("t6_applied_rst", int'(gain_applied), 0);
    applyStimulus(mkPix(100, 4'b0100, 1'b0, 100));
    applyStimulus(mkPix(100, 4'b0010, 1'b0, 100));
    applyStimulus(mkCtl(1'b1, 1'b0, 0, 0, 0));
    checkOutput("t6_no_apply", int'(gain_applied), 0);
    applyStimulus(mkPix(100, 4'b1000, 1'b0, 100));

    repeat (5) applyStimulus(mkCtl(1'b0, 1'b0, 0, 0, 0));
    checkOutput("sb_drain", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
